image_filter_stream: RTL and testbench

- Parametrised streaming 3x3 neighbourhood filter for raster-order grey-scale frames of IMG_W x IMG_H pixels.
- Successor to the fixed 128x128, 8-bit enhancement block, generalised in pixel width and frame size.
- Adds a runtime mode select (pass, smooth, sharpen, edge), per-pixel input valid with gaps, an internal end-of-frame flush, and framed output markers.
- Sits between the pixel source (file-driven bench or upstream DMA) and the output writer.

---
 rtl/image_filter_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_image_filter_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_filter_stream.sv
// Streaming 3x3 neighbourhood filter (pass/smooth/sharpen/edge) over raster frames.
// Two line buffers feed a 3x3 window; one arithmetic stage registers the result.
module image_filter_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] inp_data,
    input  logic [1:0]       mode,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             busy,
    output logic             err
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + IMG_W + 1);
    localparam int CLW  = $clog2(IMG_W);
    localparam int RWW  = $clog2(IMG_H);
    localparam int AW   = PIX_W + 4;

    localparam logic [CW-1:0]  LAST_IN   = CW'(NPIX - 1);
    localparam logic [CW-1:0]  LAST_FL   = CW'(NPIX + IMG_W);
    localparam logic [CW-1:0]  FIRST_OUT = CW'(IMG_W + 1);
    localparam logic [CLW-1:0] COL_MAX   = CLW'(IMG_W - 1);
    localparam logic [RWW-1:0] ROW_MAX   = RWW'(IMG_H - 1);
    localparam logic signed [AW-1:0] MAXV = {4'b0000, {PIX_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_b;
    logic [CLW-1:0] col_q, col_d, col_b;
    logic [CLW-1:0] ocol_q, ocol_d, ocol_b;
    logic [RWW-1:0] orow_q, orow_d, orow_b;
    logic           adv, start;

    logic s1_vld_q, s1_vld_d, s1_bord_q, s1_bord_d;
    logic s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;

    logic [PIX_W-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;

    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        err_d   = err_q;
        adv     = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && in_valid) begin
                    adv     = 1'b1;
                    start   = 1'b1;
                    state_d = RUN;
                    mode_d  = mode;
                end else if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                if (en) err_d = 1'b1;
                if (in_valid) begin
                    adv = 1'b1;
                    if (cnt_q == LAST_IN) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (en) err_d = 1'b1;
                adv = 1'b1;
                if (cnt_q == LAST_FL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters restart at frame start; cnt indexes the advance, ocol/orow the output pixel.
    always_comb begin
        cnt_b     = start ? '0 : cnt_q;
        col_b     = start ? '0 : col_q;
        ocol_b    = start ? '0 : ocol_q;
        orow_b    = start ? '0 : orow_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        ocol_d    = ocol_q;
        orow_d    = orow_q;
        s1_vld_d  = 1'b0;
        s1_bord_d = 1'b0;
        s1_sof_d  = 1'b0;
        s1_eof_d  = 1'b0;
        if (adv) begin
            cnt_d = (state_d == IDLE) ? '0 : cnt_b + CW'(1);
            col_d = (col_b == COL_MAX) ? '0 : col_b + CLW'(1);
            ocol_d = ocol_b;
            orow_d = orow_b;
            if (cnt_b >= FIRST_OUT) begin
                s1_vld_d  = 1'b1;
                s1_bord_d = (orow_b == '0) || (orow_b == ROW_MAX) ||
                            (ocol_b == '0) || (ocol_b == COL_MAX);
                s1_sof_d  = (orow_b == '0) && (ocol_b == '0);
                s1_eof_d  = (orow_b == ROW_MAX) && (ocol_b == COL_MAX);
                if (ocol_b == COL_MAX) begin
                    ocol_d = '0;
                    orow_d = (orow_b == ROW_MAX) ? '0 : orow_b + RWW'(1);
                end else begin
                    ocol_d = ocol_b + CLW'(1);
                end
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (adv) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_q[col_b];
            win_d[1][2] = lb0_q[col_b];
            win_d[2][2] = inp_data;
        end
    end

    function automatic logic signed [AW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [PIX_W-1:0] clamp(input logic signed [AW-1:0] v);
        if (v < 0)         return '0;
        else if (v > MAXV) return '1;
        else               return v[PIX_W-1:0];
    endfunction

    logic signed [AW-1:0] sum4, sumd, smooth_f, sharp_f, gx, gy, ax, ay;
    logic [PIX_W-1:0] cpix, filt;

    always_comb begin
        cpix     = win_q[1][1];
        sum4     = ext(win_q[0][1]) + ext(win_q[2][1]) + ext(win_q[1][0]) + ext(win_q[1][2]);
        sumd     = ext(win_q[0][0]) + ext(win_q[0][2]) + ext(win_q[2][0]) + ext(win_q[2][2]);
        smooth_f = (ext(cpix) <<< 2) + (sum4 <<< 1) + sumd;
        sharp_f  = (ext(cpix) <<< 2) + ext(cpix) - sum4;
        gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode_q)
            2'd1:    filt = smooth_f[PIX_W+3:4];
            2'd2:    filt = clamp(sharp_f);
            2'd3:    filt = clamp(ax + ay);
            default: filt = cpix;
        endcase
        if (s1_bord_q) filt = cpix;

        out_data_d  = s1_vld_q ? filt : out_data_q;
        out_valid_d = s1_vld_q;
        out_sof_d   = s1_vld_q & s1_sof_q;
        out_eof_d   = s1_vld_q & s1_eof_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            col_q       <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_bord_q   <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            ocol_q      <= ocol_d;
            orow_q      <= orow_d;
            s1_vld_q    <= s1_vld_d;
            s1_bord_q   <= s1_bord_d;
            s1_sof_q    <= s1_sof_d;
            s1_eof_q    <= s1_eof_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Line buffers and window carry no reset; stale contents only reach border outputs.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (adv) begin
            lb1_q[col_b] <= lb0_q[col_b];
            lb0_q[col_b] <= inp_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
endmodule

// File: tb/tb_image_filter_stream.sv
// Directed bench for image_filter_stream: 4x4 table-driven frames plus a 128x128 smooth frame.
module tb_image_filter_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, in_valid;
    logic [7:0] inp_data, out_data;
    logic [1:0] mode;
    logic       out_valid, out_sof, out_eof, busy, err;

    logic       b_en, b_in_valid;
    logic [7:0] b_inp_data, b_out_data;
    logic [1:0] b_mode;
    logic       b_out_valid, b_out_sof, b_out_eof, b_busy, b_err;

    image_filter_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .inp_data(inp_data),
        .mode(mode), .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
        .out_eof(out_eof), .busy(busy), .err(err));

    image_filter_stream big (
        .clk(clk), .rst(rst), .en(b_en), .in_valid(b_in_valid), .inp_data(b_inp_data),
        .mode(b_mode), .out_data(b_out_data), .out_valid(b_out_valid), .out_sof(b_out_sof),
        .out_eof(b_out_eof), .busy(b_busy), .err(b_err));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int od[$];
    int oc[$];
    bit os[$];
    bit oe[$];
    always @(negedge clk) if (out_valid) begin
        od.push_back(int'(out_data));
        oc.push_back(cyc);
        os.push_back(out_sof);
        oe.push_back(out_eof);
    end

    int bp[16384];
    int bout[16384];
    int bcnt = 0, beof_idx = -1, bsof_idx = -1, beof_n = 0;
    always @(negedge clk) if (b_out_valid) begin
        if (bcnt < 16384) bout[bcnt] = int'(b_out_data);
        if (b_out_eof) begin beof_idx = bcnt; beof_n++; end
        if (b_out_sof) bsof_idx = bcnt;
        bcnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int drv[16];
    int last_nb;

    // kind 0: constant 100, kind 1: 160 impulse at (1,1), kind 2: ramp 0..15
    task automatic run_frame(input int m, input int kind, input bit gap, input int abort_at,
                             input bit en_mid);
        int px, guard;
        od.delete(); oc.delete(); os.delete(); oe.delete();
        for (int i = 0; i < 16; i++) begin
            if (gap && i > 0) begin @(negedge clk); en = 0; in_valid = 0; end
            if (en_mid && i == 8) begin @(negedge clk); en = 1; in_valid = 0; end
            @(negedge clk);
            px = (kind == 0) ? 100 : (kind == 1) ? ((i == 5) ? 160 : 0) : i;
            en = (i == 0);
            in_valid = 1;
            inp_data = 8'(px);
            mode = (i == 0) ? 2'(m) : ~2'(m);
            drv[i] = cyc;
            if (i == abort_at) begin
                @(negedge clk); en = 0; in_valid = 0; rst = 1;
                #1;
                chk("abort out_data", int'(out_data), 0);
                chk("abort out_valid", int'(out_valid), 0);
                chk("abort busy", int'(busy), 0);
                @(negedge clk); rst = 0;
                od.delete();
                repeat (10) @(negedge clk);
                chk("abort no outputs", od.size(), 0);
                return;
            end
        end
        last_nb = 0;
        guard = 0;
        do begin
            @(negedge clk); en = 0; in_valid = 0;
            if (busy) last_nb++;
            guard++;
        end while (busy && guard < 100);
        if (guard >= 100) chk("frame end timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_ramp(input string tag);
        int dbad, tbad, ns, ne, exp_c;
        dbad = 0; tbad = 0; ns = 0; ne = 0;
        for (int k = 0; k < od.size(); k++) begin
            if (od[k] != k) dbad++;
            exp_c = (k + 5 < 16) ? drv[k+5] + 2 : drv[15] + 2 + (k + 5 - 15);
            if (oc[k] != exp_c) tbad++;
            ns += int'(os[k]);
            ne += int'(oe[k]);
        end
        chk({tag, " count"}, od.size(), 16);
        chk({tag, " data"}, dbad, 0);
        chk({tag, " timing"}, tbad, 0);
        chk({tag, " sof n"}, ns, 1);
        chk({tag, " eof n"}, ne, 1);
        if (od.size() == 16) begin
            chk({tag, " sof@0"}, int'(os[0]), 1);
            chk({tag, " eof@15"}, int'(oe[15]), 1);
        end
    endtask

    typedef struct {
        int m;
        int kind;
        int r;
        int c;
        int exp_in;
        int exp_bd;
    } vec_t;

    function automatic int smod(int r, int c);
        int s4, sd;
        if (r == 0 || r == 127 || c == 0 || c == 127) return bp[r*128+c];
        s4 = bp[(r-1)*128+c] + bp[(r+1)*128+c] + bp[r*128+c-1] + bp[r*128+c+1];
        sd = bp[(r-1)*128+c-1] + bp[(r-1)*128+c+1] + bp[(r+1)*128+c-1] + bp[(r+1)*128+c+1];
        return (4*bp[r*128+c] + 2*s4 + sd) >> 4;
    endfunction

    initial begin
        vec_t vt[11];
        int mis, first_bad, guard, k, ex;
        vt[0]  = '{1, 0, -1, -1, 100, 100};
        vt[1]  = '{2, 0, -1, -1, 100, 100};
        vt[2]  = '{3, 0, -1, -1, 0,   100};
        vt[3]  = '{1, 1, 1, 1, 40,  0};
        vt[4]  = '{1, 1, 1, 2, 20,  0};
        vt[5]  = '{1, 1, 2, 2, 10,  0};
        vt[6]  = '{2, 1, 1, 1, 255, 0};
        vt[7]  = '{2, 1, 1, 2, 0,   0};
        vt[8]  = '{3, 1, 1, 2, 255, 0};
        vt[9]  = '{1, 1, 0, 0, 0,   0};
        vt[10] = '{3, 1, 3, 3, 0,   0};

        rst = 1; en = 0; in_valid = 0; inp_data = 0; mode = 0;
        b_en = 0; b_in_valid = 0; b_inp_data = 0; b_mode = 0;
        repeat (2) @(negedge clk);
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset sof/eof", int'({out_sof, out_eof}), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset err", int'(err), 0);
        rst = 0;
        @(negedge clk);

        // continuous mode-0 ramp
        run_frame(0, 2, 1'b0, -1, 1'b0);
        check_ramp("ramp");
        chk("first out cycle", (oc.size() > 0) ? oc[0] : -1, drv[5] + 2);
        chk("flush busy cycles", last_nb, 5);
        chk("ramp err", int'(err), 0);

        for (int v = 0; v < 11; v++) begin
            run_frame(vt[v].m, vt[v].kind, 1'b0, -1, 1'b0);
            chk($sformatf("vec%0d count", v), od.size(), 16);
            if (od.size() == 16) begin
                if (vt[v].r < 0) begin
                    mis = 0;
                    for (int i = 0; i < 16; i++) begin
                        ex = (i / 4 == 0 || i / 4 == 3 || i % 4 == 0 || i % 4 == 3)
                             ? vt[v].exp_bd : vt[v].exp_in;
                        if (od[i] != ex) mis++;
                    end
                    chk($sformatf("vec%0d mode%0d all-pixel mismatches", v, vt[v].m), mis, 0);
                end else begin
                    chk($sformatf("vec%0d mode%0d (%0d,%0d)", v, vt[v].m, vt[v].r, vt[v].c),
                        od[vt[v].r*4 + vt[v].c], vt[v].exp_in);
                end
            end
        end

        // stalled input every other cycle
        run_frame(0, 2, 1'b1, -1, 1'b0);
        check_ramp("gap ramp");

        // en while busy sets sticky err, frame unaffected
        run_frame(0, 2, 1'b0, -1, 1'b1);
        check_ramp("en-mid ramp");
        chk("en-mid err sticky", int'(err), 1);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("err cleared", int'(err), 0);
        @(negedge clk); in_valid = 1; en = 0; inp_data = 8'd9;
        @(negedge clk); in_valid = 0;
        chk("idle in_valid err", int'(err), 1);
        chk("idle in_valid busy", int'(busy), 0);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;

        // reset mid-frame, then a clean frame
        run_frame(0, 2, 1'b0, 7, 1'b0);
        run_frame(0, 2, 1'b0, -1, 1'b0);
        check_ramp("post-abort ramp");

        // 128x128 random smooth frame
        for (int i = 0; i < 16384; i++) bp[i] = int'($urandom_range(0, 255));
        bcnt = 0; beof_idx = -1; bsof_idx = -1; beof_n = 0;
        for (int i = 0; i < 16384; i++) begin
            @(negedge clk);
            b_en = (i == 0); b_in_valid = 1; b_inp_data = 8'(bp[i]); b_mode = 2'd1;
        end
        guard = 0;
        do begin
            @(negedge clk); b_en = 0; b_in_valid = 0;
            guard++;
        end while (b_busy && guard < 400);
        if (guard >= 400) chk("big frame timeout", 1, 0);
        repeat (3) @(negedge clk);
        chk("big count", bcnt, 16384);
        mis = 0; first_bad = -1;
        k = (bcnt < 16384) ? bcnt : 16384;
        for (int i = 0; i < k; i++) begin
            if (bout[i] != smod(i / 128, i % 128)) begin
                mis++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (mis != 0)
            $display("first differing big output index %0d", first_bad);
        chk("big smooth mismatches", mis, 0);
        chk("big eof index", beof_idx, 16383);
        chk("big eof pulses", beof_n, 1);
        chk("big sof index", bsof_idx, 0);
        chk("big err", int'(b_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
